// File: rtl/hw3p2_ripple_adder.sv
// rtl/hw3p2_ripple_adder.sv - registered N-bit ripple-carry adder with carry chain capture
//
// Purpose: chain of single-bit full-adder cells (bit 0 takes cin, each
// carry-out feeds the next stage) whose sum, carry-out, signed overflow and
// internal carries are registered, giving one cycle of latency.
//
// Ports:
//   clk       in   1      rising-edge clock
//   rst_n     in   1      asynchronous active-low reset
//   valid_in  in   1      operands valid this cycle
//   a, b      in   WIDTH  operands (bit 0 = LSB)
//   cin       in   1      carry into bit 0
//   valid_out out  1      registered result valid
//   sum       out  WIDTH  registered sum
//   cout      out  1      registered carry out of MSB stage
//   ovf       out  1      registered two's-complement overflow
//   carries   out  WIDTH  registered carries C[WIDTH:1]

module hw3p2_ripple_adder #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             valid_in,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             valid_out,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic [WIDTH-1:0] carries
);

  logic [WIDTH:0]   c;
  logic [WIDTH-1:0] s;

  logic             valid_d, valid_q;
  logic [WIDTH-1:0] sum_d, sum_q;
  logic             cout_d, cout_q;
  logic             ovf_d, ovf_q;
  logic [WIDTH-1:0] carries_d, carries_q;

  // Ripple chain: each cell sees only its own operand bits and the carry of
  // the stage below, so depth grows linearly with WIDTH by design.
  always_comb begin
    c    = '0;
    s    = '0;
    c[0] = cin;
    for (int i = 0; i < WIDTH; i++) begin
      s[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
  end

  // Data registers load only on valid_in so that garbage (including X) on
  // idle operand buses never reaches the outputs.
  always_comb begin
    valid_d   = valid_in;
    sum_d     = sum_q;
    cout_d    = cout_q;
    ovf_d     = ovf_q;
    carries_d = carries_q;
    if (valid_in) begin
      sum_d     = s;
      cout_d    = c[WIDTH];
      // For WIDTH = 1 this is C[1] ^ cin, since c[0] is cin.
      ovf_d     = c[WIDTH] ^ c[WIDTH-1];
      carries_d = c[WIDTH:1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q   <= 1'b0;
      sum_q     <= '0;
      cout_q    <= 1'b0;
      ovf_q     <= 1'b0;
      carries_q <= '0;
    end else begin
      valid_q   <= valid_d;
      sum_q     <= sum_d;
      cout_q    <= cout_d;
      ovf_q     <= ovf_d;
      carries_q <= carries_d;
    end
  end

  assign valid_out = valid_q;
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;
  assign carries   = carries_q;

endmodule

// File: tb/tb_hw3p2_ripple_adder.sv
// tb/tb_hw3p2_ripple_adder.sv - self-checking bench for hw3p2_ripple_adder

module tb_hw3p2_ripple_adder;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         valid_in = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic         valid_out;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;
  logic [W-1:0] carries;

  hw3p2_ripple_adder #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .valid_in  (valid_in),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .valid_out (valid_out),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf),
    .carries   (carries)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    logic [W-1:0] carries;
  } res_t;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    res_t         r;
  } vec_t;

  res_t sb[$];
  int   total = 0;
  int   bad = 0;
  res_t last_res;

  // Arithmetic reference: carry into bit i is bit i of the add of the low i bits.
  function automatic res_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci);
    res_t        r;
    int unsigned full;
    int unsigned part;
    int unsigned m;
    full   = int'(x) + int'(y) + int'(ci);
    r.sum  = full[W-1:0];
    r.cout = full[W];
    for (int i = 1; i <= W; i++) begin
      m    = (32'd1 << i) - 32'd1;
      part = (int'(x) & m) + (int'(y) & m) + int'(ci);
      r.carries[i-1] = part[i];
    end
    r.ovf = (x[W-1] == y[W-1]) && (r.sum[W-1] != x[W-1]);
    return r;
  endfunction

  task automatic check_out(input string name);
    logic exp_v;
    res_t e;
    res_t got;
    exp_v = (sb.size() > 0);
    total++;
    if (valid_out !== exp_v) begin
      bad++;
      $display("FAIL %s valid_out: got %b want %b", name, valid_out, exp_v);
    end
    got = {sum, cout, ovf, carries};
    if (exp_v) begin
      e = sb.pop_front();
      total++;
      if (got !== e) begin
        bad++;
        $display("FAIL %s result: got sum=%b cout=%b ovf=%b carries=%b want sum=%b cout=%b ovf=%b carries=%b",
                 name, sum, cout, ovf, carries, e.sum, e.cout, e.ovf, e.carries);
      end
      last_res = e;
    end else begin
      total++;
      if (got !== last_res) begin
        bad++;
        $display("FAIL %s hold: got sum=%b cout=%b ovf=%b carries=%b want sum=%b cout=%b ovf=%b carries=%b",
                 name, sum, cout, ovf, carries, last_res.sum, last_res.cout, last_res.ovf, last_res.carries);
      end
    end
  endtask

  task automatic check_zero(input string name);
    total++;
    if ({valid_out, sum, cout, ovf, carries} !== '0) begin
      bad++;
      $display("FAIL %s zero: got valid_out=%b sum=%b cout=%b ovf=%b carries=%b want all 0",
               name, valid_out, sum, cout, ovf, carries);
    end
  endtask

  // Called at a negedge: drive, capture on posedge, check at next negedge.
  task automatic step(input logic v, input logic [W-1:0] x, input logic [W-1:0] y,
                      input logic ci, input res_t e, input string name);
    valid_in = v;
    a        = x;
    b        = y;
    cin      = ci;
    if (v) sb.push_back(e);
    @(posedge clk);
    @(negedge clk);
    check_out(name);
  endtask

  vec_t vecs[4];

  initial begin
    vecs[0] = '{a: 4'b0110, b: 4'b1010, cin: 1'b0, r: '{sum: 4'b0000, cout: 1'b1, ovf: 1'b0, carries: 4'b1110}};
    vecs[1] = '{a: 4'b1001, b: 4'b1010, cin: 1'b1, r: '{sum: 4'b0100, cout: 1'b1, ovf: 1'b1, carries: 4'b1011}};
    vecs[2] = '{a: 4'b0110, b: 4'b0101, cin: 1'b0, r: '{sum: 4'b1011, cout: 1'b0, ovf: 1'b1, carries: 4'b0100}};
    vecs[3] = '{a: 4'b1001, b: 4'b0101, cin: 1'b1, r: '{sum: 4'b1111, cout: 1'b0, ovf: 1'b0, carries: 4'b0001}};
    last_res = '0;

    // Reset held with random valid operands.
    rst_n    = 1'b0;
    valid_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      a   = W'($urandom);
      b   = W'($urandom);
      cin = 1'($urandom);
      @(negedge clk);
      check_zero("reset_hold");
    end
    rst_n = 1'b1;
    step(1'b0, '0, '0, 1'b0, '0, "post_reset_idle");

    // Directed vectors back-to-back.
    for (int i = 0; i < 4; i++)
      step(1'b1, vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].r, $sformatf("vec%0d", i));

    // Idle with X operands: outputs must hold the last result.
    for (int i = 0; i < 2; i++)
      step(1'b0, 'x, 'x, 1'bx, '0, $sformatf("idle%0d", i));

    // In-flight result discarded by asynchronous mid-cycle reset.
    valid_in = 1'b1;
    a = 4'b0011; b = 4'b0100; cin = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check_zero("async_reset");
    valid_in = 1'b0;
    @(negedge clk);
    check_zero("reset_still");
    rst_n    = 1'b1;
    last_res = '0;
    step(1'b0, '0, '0, 1'b0, '0, "after_reset_idle");

    // Exhaustive sweep, back-to-back.
    for (int ci = 0; ci < 2; ci++)
      for (int x = 0; x < 16; x++)
        for (int y = 0; y < 16; y++)
          step(1'b1, W'(x), W'(y), 1'(ci), model(W'(x), W'(y), 1'(ci)),
               $sformatf("sweep a=%0d b=%0d cin=%0d", x, y, ci));
    step(1'b0, '0, '0, 1'b0, '0, "final_idle");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hw3p2_ripple_adder.md
# hw3p2_ripple_adder

Registered N-bit ripple-carry adder built from a chain of single-bit full-adder cells; bit 0 takes the external carry-in, and each stage's carry-out feeds the next stage's carry-in. It is the arithmetic leaf used wherever a small unsigned/two's-complement add with carry-in is needed. It captures sum, carry-out, signed overflow and the internal carry chain in output registers, giving one cycle of latency.

## Interface

Parameters:
- WIDTH, 4, operand width; legal 1..32.

Ports:
- clk, input, 1, rising-edge clock.
- rst_n, input, 1, asynchronous active-low reset.
- valid_in, input, 1, operands valid this cycle.
- a, input, WIDTH, operand A (bit 0 = LSB).
- b, input, WIDTH, operand B.
- cin, input, 1, carry into bit 0 (C0).
- valid_out, output, 1, registered result valid.
- sum, output, WIDTH, registered sum bits S[WIDTH-1:0].
- cout, output, 1, registered carry out of the MSB stage (C[WIDTH]).
- ovf, output, 1, registered two's-complement overflow = C[WIDTH] XOR C[WIDTH-1].
- carries, output, WIDTH, registered internal carries C[WIDTH:1] (carries[i-1] = carry out of stage i-1).

## Operation

- Full-adder cell, per bit i: s_i = a_i ^ b_i ^ c_i; c_{i+1} = (a_i & b_i) | (c_i & (a_i ^ b_i)); c_0 = cin.
- Cells are chained strictly as a ripple: no carry-lookahead, no `+` operator on the full vector. Combinational depth is WIDTH cells.
- Arithmetic identity: {cout, sum} = a + b + cin, computed in WIDTH+1 bits with no truncation of the carry.
- ovf: for WIDTH = 1, ovf = C[1] ^ cin.
- Capture on a rising clk edge with valid_in = 1: sum, cout, ovf and carries load the new results, and valid_out goes to 1.
- Rising edge with valid_in = 0: valid_out goes to 0. sum, cout, ovf and carries hold their previous values (data registers are enabled by valid_in).
- X/Z on inputs while valid_in = 0 must not propagate into the data registers.

## Timing

- Latency: exactly 1 cycle from the edge that samples valid_in = 1 to outputs showing that result.
- Throughput: one add per cycle; back-to-back valid_in is fully supported with no bubbles.
- Reset: rst_n low forces valid_out, sum, cout, ovf and carries to 0 immediately, independent of clk.
- Reset deassertion is synchronised externally. The first capture occurs at the first rising edge with rst_n = 1.
- Reset asserted mid-stream: any in-flight result is discarded, and outputs read 0 until a new valid capture.
- No handshake or backpressure. valid_out is informational only.
- Combinational path from a/b/cin to the register D inputs must meet one clk period at WIDTH ripple stages.

## Test plan

- Reset: hold rst_n = 0 with random inputs, then release -> valid_out = 0, sum = 0, cout = 0, ovf = 0, carries = 0 before the first valid edge.
- WIDTH = 4, cin = 0, a = 4'b0110, b = 4'b1010 -> next cycle sum = 4'b0000, cout = 1, ovf = 0, carries = 4'b1110.
- cin = 1, a = 4'b1001, b = 4'b1010 -> sum = 4'b0100, cout = 1, ovf = 1, carries = 4'b1011.
- cin = 0, a = 4'b0110, b = 4'b0101 -> sum = 4'b1011, cout = 0, ovf = 1, carries = 4'b0100.
- cin = 1, a = 4'b1001, b = 4'b0101 -> sum = 4'b1111, cout = 0, ovf = 0, carries = 4'b0001.
- Apply the four vectors above back-to-back, then valid_in = 0 for 2 cycles, then assert rst_n = 0 asynchronously mid-cycle:
  - each result appears exactly 1 cycle after its input;
  - outputs hold 4'b1111 / cout 0 while valid_in = 0;
  - all outputs drop to 0 immediately on reset.
  - Additionally, run an exhaustive 4-bit a, b, cin sweep against the a + b + cin reference.
